// File: rtl/pe_mc_pkg.sv
// Shared constants and helpers for the PE multicast router.
package pe_mc_pkg;

   localparam int unsigned CH_WEIGHT = 0;
   localparam int unsigned CH_IFMAP  = 1;
   localparam int unsigned CH_PSUM   = 2;

   // All-ones ID of the given width (1..32); callers truncate to their ID width.
   function automatic logic [31:0] bcast_id(input int unsigned width);
      return 32'hFFFF_FFFF >> (32 - width);
   endfunction

   // Enough bits to hold an occupancy of 0..depth inclusive.
   function automatic int unsigned lvl_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/mc_fifo.sv
// Per-channel circular FIFO with push/pop/flush and an occupancy counter.
module mc_fifo
   import pe_mc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned LVL_W      = lvl_width(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [LVL_W-1:0]      level,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam logic [LVL_W-1:0] DepthLvl = LVL_W'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]      level_q;
   logic                  wr_en, rd_en;

   always_comb begin
      full  = (level_q == DepthLvl);
      empty = (level_q == '0);
      wr_en = push && !full && !flush;
      rd_en = pop && !empty && !flush;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // Head is read straight out of the storage flops, so it only moves on a pop.
   assign head_data = mem_q[rd_ptr_q];
   assign level     = level_q;

endmodule

// File: rtl/pe_mc_router.sv
// Multicast router between the column buses and one PE: ID match, per-channel FIFO.
module pe_mc_router
   import pe_mc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned NUM_CH     = 3,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned LVL_W      = lvl_width(FIFO_DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         config_state,
   input  logic                         ce,
   input  logic [NUM_CH*ID_WIDTH-1:0]   cfg_id,
   input  logic                         flush,
   input  logic [NUM_CH*ID_WIDTH-1:0]   bus_id,
   input  logic [NUM_CH*DATA_WIDTH-1:0] bus_data,
   input  logic [NUM_CH-1:0]            bus_valid,
   output logic [NUM_CH-1:0]            bus_ready,
   output logic [NUM_CH*DATA_WIDTH-1:0] pe_data,
   output logic [NUM_CH-1:0]            pe_valid,
   input  logic [NUM_CH-1:0]            pe_ready,
   output logic [NUM_CH*LVL_W-1:0]      fifo_level,
   output logic [NUM_CH-1:0]            id_loaded
);

   localparam logic [ID_WIDTH-1:0] BcastId = ID_WIDTH'(bcast_id(ID_WIDTH));

   logic [ID_WIDTH-1:0] dest_id_q [NUM_CH];
   logic [NUM_CH-1:0]   id_loaded_q;
   logic [NUM_CH-1:0]   match, full, empty, push;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) dest_id_q[c] <= '0;
         id_loaded_q <= '0;
      end else if (config_state && ce) begin
         for (int c = 0; c < NUM_CH; c++) dest_id_q[c] <= cfg_id[c*ID_WIDTH +: ID_WIDTH];
         id_loaded_q <= '1;
      end
   end

   assign id_loaded = id_loaded_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [ID_WIDTH-1:0] ch_id;

      // bus_ready depends only on match and full, never on pe_ready.
      always_comb begin
         ch_id        = bus_id[c*ID_WIDTH +: ID_WIDTH];
         match[c]     = id_loaded_q[c] && !config_state &&
                        ((ch_id == dest_id_q[c]) || (ch_id == BcastId));
         bus_ready[c] = !match[c] || !full[c];
         push[c]      = bus_valid[c] && match[c] && !full[c] && !flush;
         pe_valid[c]  = !empty[c];
      end

      mc_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH),
         .LVL_W      (LVL_W)
      ) u_fifo (
         .clk        (clk),
         .rst        (rst),
         .push       (push[c]),
         .push_data  (bus_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .pop        (pe_ready[c]),
         .flush      (flush),
         .head_data  (pe_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .level      (fifo_level[c*LVL_W +: LVL_W]),
         .full       (full[c]),
         .empty      (empty[c])
      );
   end

endmodule

// File: tb/tb_pe_mc_router.sv
// Scoreboard bench for pe_mc_router: a reference model predicts accepts and PE-side data.
module tb_pe_mc_router;
   import pe_mc_pkg::*;

   localparam int unsigned DW    = 16;
   localparam int unsigned IW    = 8;
   localparam int unsigned NCH   = 3;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LW    = 3;

   logic              clk = 1'b0;
   logic              rst, config_state, ce, flush;
   logic [NCH*IW-1:0] cfg_id, bus_id;
   logic [NCH*DW-1:0] bus_data, pe_data;
   logic [NCH-1:0]    bus_valid, bus_ready, pe_valid, pe_ready, id_loaded;
   logic [NCH*LW-1:0] fifo_level;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [IW-1:0] m_id [NCH];
   logic [NCH-1:0] m_loaded;
   int            m_lvl [NCH];
   logic [DW-1:0] sb [NCH][$];

   pe_mc_router #(
      .DATA_WIDTH (DW),
      .ID_WIDTH   (IW),
      .NUM_CH     (NCH),
      .FIFO_DEPTH (DEPTH),
      .LVL_W      (LW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .config_state (config_state),
      .ce           (ce),
      .cfg_id       (cfg_id),
      .flush        (flush),
      .bus_id       (bus_id),
      .bus_data     (bus_data),
      .bus_valid    (bus_valid),
      .bus_ready    (bus_ready),
      .pe_data      (pe_data),
      .pe_valid     (pe_valid),
      .pe_ready     (pe_ready),
      .fifo_level   (fifo_level),
      .id_loaded    (id_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int ch, input logic v, input logic [IW-1:0] id,
                        input logic [DW-1:0] d);
      bus_valid[ch]        = v;
      bus_id[ch*IW +: IW]  = id;
      bus_data[ch*DW +: DW] = d;
   endtask

   // Monitor: compare DUT against the model each cycle, then advance the model.
   always @(negedge clk) begin
      if (rst) begin
         m_loaded = '0;
         for (int c = 0; c < NCH; c++) begin
            m_id[c]  = '0;
            m_lvl[c] = 0;
            sb[c].delete();
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            logic [IW-1:0] id;
            logic          mt, wr, rd;
            id = bus_id[c*IW +: IW];
            mt = m_loaded[c] && !config_state && (id == m_id[c] || id == 8'hFF);
            check($sformatf("bus_ready[%0d]", c), 32'(bus_ready[c]),
                  32'(!mt || m_lvl[c] < int'(DEPTH)));
            check($sformatf("pe_valid[%0d]", c), 32'(pe_valid[c]), 32'(m_lvl[c] != 0));
            check($sformatf("fifo_level[%0d]", c), 32'(fifo_level[c*LW +: LW]), 32'(m_lvl[c]));
            wr = bus_valid[c] && mt && (m_lvl[c] < int'(DEPTH)) && !flush;
            rd = (m_lvl[c] != 0) && pe_ready[c] && !flush;
            if (rd && sb[c].size() > 0)
               check($sformatf("pe_data[%0d]", c), 32'(pe_data[c*DW +: DW]),
                     32'(sb[c].pop_front()));
            if (wr) sb[c].push_back(bus_data[c*DW +: DW]);
            if (flush) begin
               sb[c].delete();
               m_lvl[c] = 0;
            end else begin
               m_lvl[c] = m_lvl[c] + int'(wr) - int'(rd);
            end
         end
         if (config_state && ce) begin
            for (int c = 0; c < NCH; c++) m_id[c] = cfg_id[c*IW +: IW];
            m_loaded = '1;
         end
      end
   end

   initial begin
      logic accepted;
      rst = 1'b1; config_state = 1'b0; ce = 1'b0; flush = 1'b0;
      cfg_id = '0; bus_id = '0; bus_data = '0; bus_valid = '0; pe_ready = '0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      check("rst bus_ready", 32'(bus_ready), 32'h7);
      check("rst pe_valid", 32'(pe_valid), 32'h0);
      check("rst pe_data", 32'(pe_data[DW-1:0]), 32'h0);
      check("rst fifo_level", 32'(fifo_level), 32'h0);
      check("rst id_loaded", 32'(id_loaded), 32'h0);

      // Unconfigured channel ignores traffic
      drive(CH_WEIGHT, 1'b1, 8'h05, 16'h0055);
      step();
      check("unconf bus_ready", 32'(bus_ready[CH_WEIGHT]), 32'h1);
      step();
      check("unconf pe_valid", 32'(pe_valid[CH_WEIGHT]), 32'h0);
      check("unconf level", 32'(fifo_level[CH_WEIGHT*LW +: LW]), 32'h0);

      // Configure: ch0=0x05, ch1=0x03, ch2=0x07; bus traffic held off during config
      config_state = 1'b1; ce = 1'b1; cfg_id = {8'h07, 8'h03, 8'h05};
      step();
      ce = 1'b0;
      check("cfg id_loaded", 32'(id_loaded), 32'h7);
      check("cfg bus_ready", 32'(bus_ready), 32'h7);
      check("cfg no write", 32'(pe_valid[CH_WEIGHT]), 32'h0);
      config_state = 1'b0;
      drive(CH_WEIGHT, 1'b0, 8'h00, 16'h0);

      // Unicast on ch0
      pe_ready = 3'b111;
      for (int i = 0; i < 3; i++) begin
         drive(CH_WEIGHT, 1'b1, 8'h05, 16'(16'hA1 + i));
         step();
      end
      drive(CH_WEIGHT, 1'b0, 8'h00, 16'h0);
      step();
      step();

      // Non-match then broadcast on ch1
      drive(CH_IFMAP, 1'b1, 8'h04, 16'h0011);
      step();
      drive(CH_IFMAP, 1'b1, 8'hFF, 16'h0022);
      step();
      drive(CH_IFMAP, 1'b0, 8'h00, 16'h0);
      step();
      step();

      // Fill ch2 and hold the 5th beat against backpressure
      pe_ready[CH_PSUM] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(CH_PSUM, 1'b1, 8'h07, 16'(16'hB1 + i));
         step();
      end
      drive(CH_PSUM, 1'b1, 8'h07, 16'hB5);
      #1;
      check("full level", 32'(fifo_level[CH_PSUM*LW +: LW]), 32'h4);
      check("full bus_ready", 32'(bus_ready[CH_PSUM]), 32'h0);
      step();
      pe_ready[CH_PSUM] = 1'b1;
      accepted = 1'b0;
      for (int k = 0; k < 8 && !accepted; k++) begin
         accepted = bus_ready[CH_PSUM];
         step();
      end
      check("5th beat accepted", 32'(accepted), 32'h1);
      drive(CH_PSUM, 1'b0, 8'h00, 16'h0);
      for (int k = 0; k < 6; k++) step();

      // Simultaneous push and pop at level 2 on ch0
      pe_ready[CH_WEIGHT] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(CH_WEIGHT, 1'b1, 8'h05, 16'(16'hC1 + i));
         step();
      end
      pe_ready[CH_WEIGHT] = 1'b1;
      for (int i = 2; i < 6; i++) begin
         drive(CH_WEIGHT, 1'b1, 8'h05, 16'(16'hC1 + i));
         step();
         check("pushpop level", 32'(fifo_level[CH_WEIGHT*LW +: LW]), 32'h2);
      end
      drive(CH_WEIGHT, 1'b0, 8'h00, 16'h0);
      for (int k = 0; k < 3; k++) step();

      // Config raised mid-stream, one pop, then flush
      pe_ready[CH_WEIGHT] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(CH_WEIGHT, 1'b1, 8'h05, 16'(16'hD1 + i));
         step();
      end
      config_state = 1'b1;
      drive(CH_WEIGHT, 1'b1, 8'h05, 16'h00EE);
      step();
      check("cfg hold level", 32'(fifo_level[CH_WEIGHT*LW +: LW]), 32'h3);
      pe_ready[CH_WEIGHT] = 1'b1;
      step();
      pe_ready[CH_WEIGHT] = 1'b0;
      check("cfg drain level", 32'(fifo_level[CH_WEIGHT*LW +: LW]), 32'h2);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush level", 32'(fifo_level[CH_WEIGHT*LW +: LW]), 32'h0);
      check("flush pe_valid", 32'(pe_valid), 32'h0);
      check("flush id_loaded", 32'(id_loaded), 32'h7);
      config_state = 1'b0;
      drive(CH_WEIGHT, 1'b1, 8'h05, 16'h00F0);
      step();
      drive(CH_WEIGHT, 1'b0, 8'h00, 16'h0);
      check("post-flush pe_valid", 32'(pe_valid[CH_WEIGHT]), 32'h1);
      check("post-flush pe_data", 32'(pe_data[CH_WEIGHT*DW +: DW]), 32'h00F0);
      pe_ready[CH_WEIGHT] = 1'b1;
      for (int k = 0; k < 3; k++) step();

      for (int c = 0; c < NCH; c++)
         check($sformatf("drained[%0d]", c), 32'(sb[c].size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/pe_mc_router.md
# pe_mc_router

Parametrised multicast router that sits between the shared column buses and one PE in the PE array. It generalises the per-stream weight, ifmap and psum-in routers into one block serving NUM_CH independent channels. Each channel has:
- a configurable destination ID;
- broadcast-ID support;
- a FIFO buffer;
- full ready/valid backpressure on both the bus side and the PE side.

## Interface
Parameters:
- DATA_WIDTH, 16, data beat width per channel
- ID_WIDTH, 8, width of source and destination IDs
- NUM_CH, 3, number of independent channels (0 weight, 1 ifmap, 2 psum-in by convention)
- FIFO_DEPTH, 4, per-channel buffer depth; power of two, ≥ 2
- LVL_W, $clog2(FIFO_DEPTH+1), fill-level width

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- config_state  in  1  config phase; while high, no data beat is accepted
- ce  in  1  ID load strobe; effective only when config_state=1
- cfg_id  in  NUM_CH*ID_WIDTH  per-channel destination ID (channel c at bits [c*ID_WIDTH +: ID_WIDTH])
- flush  in  1  empties all FIFOs; IDs are kept
- bus_id  in  NUM_CH*ID_WIDTH  per-channel source/target ID of the current bus beat
- bus_data  in  NUM_CH*DATA_WIDTH  per-channel bus data
- bus_valid  in  NUM_CH  bus beat valid
- bus_ready  out  NUM_CH  this PE's contribution to the bus ready AND-tree
- pe_data  out  NUM_CH*DATA_WIDTH  data to the PE
- pe_valid  out  NUM_CH  FIFO head valid
- pe_ready  in  NUM_CH  PE pops the head
- fifo_level  out  NUM_CH*LVL_W  current occupancy per channel
- id_loaded  out  NUM_CH  channel has been configured since reset

## Operation
- **Configuration:** when config_state=1 and ce=1, every channel latches dest_id[c]=cfg_id[c] and sets id_loaded[c]=1. Repeated ce overwrites the ID.
- **Match:** match[c] is true when all of the following hold:
  - id_loaded[c]=1;
  - config_state=0;
  - bus_id[c]==dest_id[c], or bus_id[c]=={ID_WIDTH{1'b1}} (broadcast).
- **bus_ready[c]:** equals !match[c] || !full[c].
  - Non-targeted PEs never stall the bus.
  - Unconfigured channels ignore all traffic.
  - During config_state=1, bus_ready is all 1s.
- **Write:** bus_valid[c] && match[c] && !full[c] && !flush.
- **Read:** pe_valid[c] && pe_ready[c].
- **FIFO:** circular buffer with wrap-around pointers and an occupancy counter.
  - full = level==FIFO_DEPTH; empty = level==0.
  - Channels are fully independent; there is no cross-channel ordering.
- **Read and write in the same cycle:** level is unchanged. This is legal at any level except full, where the write is refused because bus_ready is low.
- **flush:** in the next cycle level=0, pe_valid=0 and pointers are 0. A write or read in the flush cycle is discarded. Config is unaffected.
- **config_state rising mid-stream:** buffered beats are retained and still drain to the PE. Only new writes are blocked.
- **Reset:** all outputs and state return to their reset values (see Timing).

## Timing
- **Reset values:** bus_ready all 1s, pe_valid=0, pe_data=0, fifo_level=0, id_loaded=0, dest_id=0, pointers 0.
- **Write to PE latency:** 1 cycle. A beat accepted at edge N gives pe_valid=1 with that data after edge N, when the FIFO was empty.
- **pe_data** is a registered head (registered output, or RAM read-ahead). It is stable while pe_valid=1 and pe_ready=0.
- **bus_ready** is combinational from bus_id, config state and the full flag only. There is no path from pe_ready to bus_ready.
- **Throughput:** 1 beat per cycle per channel, sustained, when pe_ready is held high.
- **Level update:** fifo_level updates on the edge after the push or pop.
- **ID load:** an ID loaded at edge N is used for matching from cycle N+1.

## Structure
- Package pe_mc_pkg:
  - BCAST_ID constant/function (all-ones of ID_WIDTH);
  - channel index constants CH_WEIGHT=0, CH_IFMAP=1, CH_PSUM=2;
  - level-width helper.
- Sub-module mc_fifo (DATA_WIDTH, FIFO_DEPTH): a push/pop/flush FIFO with level, full and empty. It is instantiated NUM_CH times in a generate loop.
- The top level holds the dest_id/id_loaded registers and the match and ready logic.

## Test plan
- **Reset then unconfigured traffic:**
  - Stimulus: rst for 2 cycles; then bus_valid=1, bus_id=0x05 on ch0.
  - Required response: bus_ready[0]=1, pe_valid[0]=0, fifo_level[0]=0.
- **Unicast after configuration:**
  - Stimulus: config ch0 to 0x05 via ce; drop config_state; send 3 beats 0xA1/0xA2/0xA3 with id 0x05, pe_ready=1.
  - Required response: pe_data sequence 0xA1/0xA2/0xA3, each 1 cycle after acceptance.
- **Non-match and broadcast:**
  - Stimulus: ch1 configured to 0x03; send id 0x04 data 0x11, then id 0xFF data 0x22.
  - Required response: only 0x22 arrives; bus_ready stays 1 throughout.
- **Full and backpressure:**
  - Stimulus: pe_ready=0; push 5 matching beats into a depth-4 channel.
  - Required response: level=4 and bus_ready=0 on the 5th beat. After raising pe_ready, beats 1–5 drain in order.
- **Simultaneous push/pop at level 2:**
  - Stimulus: push and pop in the same cycle.
  - Required response: level stays 2; order is preserved.
- **Flush and config mid-stream:**
  - Stimulus: level 3, raise config_state; pop one; then flush.
  - Required response: level goes 3→2 with no new writes during config; after flush, level=0 and pe_valid=0. The dest ID is unchanged after the flush.
